// File: rtl/dmem_access_unit.sv
// Load/store sequencer between the MEM stage and data_memory. Aligned accesses go
// straight through; misaligned half/word accesses become big-endian byte sequences.
module dmem_access_unit #(
  parameter int DATA_MEM_SIZE = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_width,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [1:0]  MemWidth,
  output logic        SignExtend,
  output logic [31:0] Address1,
  output logic [31:0] WriteAddress,
  output logic [31:0] WriteData,
  input  logic [31:0] ReadData1
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    SPLIT  = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [32:0] MEM_LIMIT = 33'(DATA_MEM_SIZE);

  state_t      state, next_state;
  logic [1:0]  k, next_k;
  logic        lat_write, lat_signed;
  logic [1:0]  lat_width, lat_last;
  logic [31:0] lat_addr, lat_wdata;
  logic [23:0] acc;

  logic [1:0]  req_last;
  logic [32:0] req_end;
  logic        req_bad, req_aligned;

  logic        cur_write, cur_signed;
  logic [1:0]  cur_width, cur_last, byte_sel;
  logic [31:0] cur_addr, cur_wdata;

  logic        nxt_read, nxt_write, nxt_sext;
  logic [1:0]  nxt_width;
  logic [31:0] nxt_addr, nxt_wdata;
  logic [31:0] split_word, load_result, nxt_rdata;

  function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [1:0] sel);
    logic [7:0] b;
    case (sel)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'd0;
    endcase
    return b;
  endfunction

  // Classify the incoming request: index of its last byte, range and alignment.
  always_comb begin
    req_last    = 2'd0;
    req_aligned = 1'b0;
    case (req_width)
      2'b00: begin
        req_last    = 2'd0;
        req_aligned = 1'b1;
      end
      2'b01: begin
        req_last    = 2'd1;
        req_aligned = ~req_addr[0];
      end
      2'b10: begin
        req_last    = 2'd3;
        req_aligned = (req_addr[1:0] == 2'b00);
      end
      default: begin
        req_last    = 2'd3;
        req_aligned = 1'b0;
      end
    endcase
    req_end = {1'b0, req_addr} + {31'd0, req_last};
    req_bad = (req_width == 2'b11) || (req_end >= MEM_LIMIT);
  end

  // In IDLE the live request fields drive the next access, otherwise the latched ones.
  always_comb begin
    if (state == IDLE) begin
      cur_write  = req_write;
      cur_width  = req_width;
      cur_signed = req_signed;
      cur_addr   = req_addr;
      cur_wdata  = req_wdata;
      cur_last   = req_last;
    end else begin
      cur_write  = lat_write;
      cur_width  = lat_width;
      cur_signed = lat_signed;
      cur_addr   = lat_addr;
      cur_wdata  = lat_wdata;
      cur_last   = lat_last;
    end
  end

  always_comb begin
    next_state = state;
    next_k     = k;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_bad) begin
            next_state = RESP;
          end else if (req_aligned) begin
            next_state = ACCESS;
          end else begin
            next_state = SPLIT;
            next_k     = 2'd0;
          end
        end else begin
          next_state = IDLE;
        end
      end
      ACCESS: next_state = RESP;
      SPLIT: begin
        if (k == lat_last) begin
          next_state = RESP;
        end else begin
          next_k = k + 2'd1;
        end
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Memory port values for the coming cycle; split stores send the MSB first.
  always_comb begin
    nxt_read  = 1'b0;
    nxt_write = 1'b0;
    nxt_width = 2'b00;
    nxt_sext  = 1'b0;
    nxt_addr  = 32'd0;
    nxt_wdata = 32'd0;
    byte_sel  = cur_last - next_k;
    case (next_state)
      ACCESS: begin
        nxt_read  = ~cur_write;
        nxt_write = cur_write;
        nxt_width = cur_width;
        nxt_sext  = cur_signed;
        nxt_addr  = cur_addr;
        if (cur_write) begin
          nxt_wdata = cur_wdata;
        end else begin
          nxt_wdata = 32'd0;
        end
      end
      SPLIT: begin
        nxt_read  = ~cur_write;
        nxt_write = cur_write;
        nxt_addr  = cur_addr + {30'd0, next_k};
        if (cur_write) begin
          nxt_wdata = {24'd0, byte_of(cur_wdata, byte_sel)};
        end else begin
          nxt_wdata = 32'd0;
        end
      end
      default: nxt_read = 1'b0;
    endcase
  end

  // Load data is taken straight from the memory on the edge that closes the access.
  always_comb begin
    split_word  = {acc, ReadData1[7:0]};
    load_result = 32'd0;
    if (state == ACCESS) begin
      load_result = ReadData1;
    end else if (state == SPLIT) begin
      if (lat_width == 2'b01) begin
        load_result = {{16{lat_signed & split_word[15]}}, split_word[15:0]};
      end else begin
        load_result = split_word;
      end
    end else begin
      load_result = 32'd0;
    end
    if ((state == IDLE) || lat_write) begin
      nxt_rdata = 32'd0;
    end else begin
      nxt_rdata = load_result;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      k            <= 2'd0;
      lat_write    <= 1'b0;
      lat_width    <= 2'b00;
      lat_signed   <= 1'b0;
      lat_addr     <= 32'd0;
      lat_wdata    <= 32'd0;
      lat_last     <= 2'd0;
      acc          <= 24'd0;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_err     <= 1'b0;
      resp_rdata   <= 32'd0;
      MemRead      <= 1'b0;
      MemWrite     <= 1'b0;
      MemWidth     <= 2'b00;
      SignExtend   <= 1'b0;
      Address1     <= 32'd0;
      WriteAddress <= 32'd0;
      WriteData    <= 32'd0;
    end else begin
      state <= next_state;
      k     <= next_k;
      if ((state == IDLE) && req_valid) begin
        lat_write  <= req_write;
        lat_width  <= req_width;
        lat_signed <= req_signed;
        lat_addr   <= req_addr;
        lat_wdata  <= req_wdata;
        lat_last   <= req_last;
        acc        <= 24'd0;
      end else if (state == SPLIT) begin
        acc <= split_word[23:0];
      end
      req_ready    <= (next_state == IDLE);
      resp_valid   <= (next_state == RESP);
      resp_err     <= (next_state == RESP) && (state == IDLE);
      if (next_state == RESP) begin
        resp_rdata <= nxt_rdata;
      end
      MemRead      <= nxt_read;
      MemWrite     <= nxt_write;
      MemWidth     <= nxt_width;
      SignExtend   <= nxt_sext;
      Address1     <= nxt_addr;
      WriteAddress <= nxt_addr;
      WriteData    <= nxt_wdata;
    end
  end

endmodule
